counter_input_ctrl: RTL and testbench
=====================================

# counter_input_ctrl

Front-end control stage that sits directly upstream of the up/down counter and drives its `enable`, `up_down`, `set` and `set_value` inputs. It turns three asynchronous, bouncing push-buttons and a 4-bit switch bank into clean, registered counter controls. Each input goes through a 2-FF synchronizer, a per-button debounce counter and a rising-edge detector. Run and direction presses toggle level controls; a load press produces a single-cycle `set` pulse with a captured value.

## Interface
- `DEBOUNCE_CYCLES`, default 4: number of consecutive cycles a synchronized input must differ from its debounced state before the debounced state flips. Legal range is 1..65535.
- `CNT_W`, default 16: width of each debounce counter. It must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `btn_run`  in  1  asynchronous push-button. Each debounced press toggles `enable`.
- `btn_dir`  in  1  asynchronous push-button. Each debounced press toggles `up_down`.
- `btn_load`  in  1  asynchronous push-button. Each debounced press issues a `set` pulse.
- `sw_value`  in  4  asynchronous switch bank; this is the load value.
- `enable`  out  1  registered count enable for the counter.
- `up_down`  out  1  registered direction: 1 = up, 0 = down.
- `set`  out  1  registered one-cycle load strobe.
- `set_value`  out  4  registered load value. It is valid and stable whenever `set`=1.

## Operation
- Synchronizers:
  - Each of `btn_run`, `btn_dir` and `btn_load` passes through 2 flops.
  - `sw_value` passes through a 4-bit 2-flop synchronizer.
- Debounce, per button:
  - Each button has a stable state `db` and a counter `dc`.
  - If `sync2 == db`, then `dc` ← 0.
  - Otherwise, if `dc == DEBOUNCE_CYCLES-1`, then `db` ← `sync2` and `dc` ← 0.
  - Otherwise, `dc` ← `dc`+1.
  - Any input pulse or gap shorter than DEBOUNCE_CYCLES synchronized cycles is rejected. Press and release are filtered identically.
- Edge detect: `rise` = `db` & ~`db_d`, where `db_d` is `db` delayed by one cycle. `rise` is high for exactly 1 cycle per accepted press.
- Actions, taken on the clock edge where `rise` is high:
  - run: `enable` ← ~`enable`.
  - dir: `up_down` ← ~`up_down`.
  - load: `set` ← 1 and `set_value` ← synchronized `sw_value`.
- `set` is 0 on every other cycle. `set_value` holds its value between loads.
- Simultaneous edges: the three actions are independent and all take effect on the same edge. No priority applies.
- A held button produces exactly one action per press. A new action needs a debounced release followed by a debounced press.
- Reset, including mid-operation: all synchronizer flops, `db`, `db_d` and `dc` clear to 0. Outputs reset to `enable`=0, `up_down`=1, `set`=0, `set_value`=4'h0.
- A button held through reset is treated as a new press once the debounce completes after reset is released.

## Timing
- Let posedge N be the first edge that samples a button high.
  - `sync2`=1 after edge N+1.
  - `db`=1 after edge N+1+DEBOUNCE_CYCLES.
  - The output changes after edge N+2+DEBOUNCE_CYCLES.
  - Total latency is DEBOUNCE_CYCLES+2 edges, i.e. 6 edges at the default.
- `sw_value` must be stable for at least 3 cycles before the load action edge to be captured.
- Release latency is the same. `db` returns to 0 DEBOUNCE_CYCLES+1 edges after the first low sample.
- `set` is high for exactly 1 cycle. The counter sees it in the same cycle it sees the new `set_value`.
- No combinational path exists from any input to any output.
- `dc` never exceeds DEBOUNCE_CYCLES-1, so it cannot wrap.

## Test plan
- Reset: hold `reset` for 5 cycles with all buttons at 0. Required: `enable`=0, `up_down`=1, `set`=0, `set_value`=0 on every cycle, and all stay so for 20 cycles after release.
- Clean run press: with DEBOUNCE_CYCLES=4, hold `btn_run`=1 for 10 cycles. Required: `enable` goes 0→1 exactly 6 edges after the first sampling edge and stays 1; `set` stays 0. Release, then press again for 10 cycles. Required: `enable` returns to 0.
- Bounce rejection: drive `btn_dir` with the pattern 1,0,1,1,0,1 cycle by cycle, then hold 1 for 8 cycles. Required: `up_down` toggles exactly once (1→0), 6 edges after the start of the steady hold. Glitches of 1-3 cycles cause no toggle.
- Load: set `sw_value`=4'hA, then press `btn_load` for 8 cycles. Required: `set`=1 for exactly one cycle with `set_value`=4'hA; `enable` and `up_down` are unchanged. Change `sw_value` to 4'h3 without pressing. Required: `set_value` stays 4'hA.
- Simultaneous presses: press `btn_run`, `btn_dir` and `btn_load` in the same cycle with `sw_value`=4'h5. Required: on the same edge `enable` toggles, `up_down` toggles, `set`=1 and `set_value`=4'h5.
- Reset mid-operation: with `enable`=1 and `up_down`=0, assert `reset` for 1 cycle while `btn_run` is held. Required: outputs return to their reset values on the next edge. After reset is released, `enable` goes to 1 six edges later, because the held button counts as a fresh press.

Source files
------------

// File: rtl/counter_input_ctrl.sv
// Push-button and switch front end for the up/down counter.
// Synchronizes, debounces and edge-detects buttons into registered controls.
module counter_input_ctrl_btn_stage #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic rise
);

    localparam logic [CNT_W-1:0] DC_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             db;
    logic             db_d;
    logic [CNT_W-1:0] dc;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            db    <= 1'b0;
            db_d  <= 1'b0;
            dc    <= '0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            db_d  <= db;
            if (sync2 == db) begin
                dc <= '0;
            end else if (dc == DC_MAX) begin
                db <= sync2;
                dc <= '0;
            end else begin
                dc <= dc + CNT_W'(1);
            end
        end
    end

    // Only a debounced 0->1 transition counts as a press.
    assign rise = db & ~db_d;

endmodule

module counter_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_run,
    input  logic       btn_dir,
    input  logic       btn_load,
    input  logic [3:0] sw_value,
    output logic       enable,
    output logic       up_down,
    output logic       set,
    output logic [3:0] set_value
);

    logic       run_rise;
    logic       dir_rise;
    logic       load_rise;
    logic [3:0] sw_sync1;
    logic [3:0] sw_sync2;

    counter_input_ctrl_btn_stage #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_run (
        .clk  (clk),
        .reset(reset),
        .btn  (btn_run),
        .rise (run_rise)
    );

    counter_input_ctrl_btn_stage #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_dir (
        .clk  (clk),
        .reset(reset),
        .btn  (btn_dir),
        .rise (dir_rise)
    );

    counter_input_ctrl_btn_stage #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_load (
        .clk  (clk),
        .reset(reset),
        .btn  (btn_load),
        .rise (load_rise)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            sw_sync1 <= 4'h0;
            sw_sync2 <= 4'h0;
        end else begin
            sw_sync1 <= sw_value;
            sw_sync2 <= sw_sync1;
        end
    end

    // Actions are independent; simultaneous presses all land on one edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            enable    <= 1'b0;
            up_down   <= 1'b1;
            set       <= 1'b0;
            set_value <= 4'h0;
        end else begin
            set <= load_rise;
            if (run_rise) begin
                enable <= ~enable;
            end
            if (dir_rise) begin
                up_down <= ~up_down;
            end
            if (load_rise) begin
                set_value <= sw_sync2;
            end
        end
    end

endmodule

// File: tb/tb_counter_input_ctrl.sv
// Directed self-checking bench for counter_input_ctrl.
module tb_counter_input_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_run;
    logic       btn_dir;
    logic       btn_load;
    logic [3:0] sw_value;
    logic       enable;
    logic       up_down;
    logic       set;
    logic [3:0] set_value;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    counter_input_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_run  (btn_run),
        .btn_dir  (btn_dir),
        .btn_load (btn_load),
        .sw_value (sw_value),
        .enable   (enable),
        .up_down  (up_down),
        .set      (set),
        .set_value(set_value)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        btn_run  = 1'b0;
        btn_dir  = 1'b0;
        btn_load = 1'b0;
        sw_value = 4'h0;
        for (int i = 0; i < 25; i++) begin
            if (i == 5) reset = 1'b0;
            tick();
            tests++;
            if ({enable, up_down, set, set_value} !== 7'b0100000) begin
                failed++;
                $display("FAIL reset cyc=%0d got en=%b ud=%b set=%b val=%h want 0 1 0 0",
                         i, enable, up_down, set, set_value);
            end
        end
    endtask

    task automatic run_press(input logic exp_before);
        logic exp;
        btn_run = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            exp = (i >= 7) ? ~exp_before : exp_before;
            tests++;
            if (enable !== exp || set !== 1'b0) begin
                failed++;
                $display("FAIL run_press tick=%0d got en=%b set=%b want en=%b set=0",
                         i, enable, set, exp);
            end
        end
        btn_run = 1'b0;
        idle(10);
    endtask

    task automatic test_run();
        run_press(1'b0);
        run_press(1'b1);
    endtask

    task automatic test_bounce();
        logic [5:0] pat;
        logic       exp;
        pat = 6'b101101;
        for (int i = 1; i <= 14; i++) begin
            btn_dir = (i <= 6) ? pat[6-i] : 1'b1;
            tick();
            exp = (i >= 12) ? 1'b0 : 1'b1;
            tests++;
            if (up_down !== exp) begin
                failed++;
                $display("FAIL bounce tick=%0d got ud=%b want %b", i, up_down, exp);
            end
        end
        btn_dir = 1'b0;
        idle(10);
        tests++;
        if (up_down !== 1'b0) begin
            failed++;
            $display("FAIL bounce_hold got ud=%b want 0", up_down);
        end
    endtask

    task automatic test_load();
        logic       exp_set;
        logic [3:0] exp_val;
        sw_value = 4'hA;
        idle(3);
        btn_load = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            exp_set = (i == 7);
            exp_val = (i >= 7) ? 4'hA : 4'h0;
            tests++;
            if (set !== exp_set || set_value !== exp_val ||
                enable !== 1'b0 || up_down !== 1'b0) begin
                failed++;
                $display("FAIL load tick=%0d got set=%b val=%h en=%b ud=%b want %b %h 0 0",
                         i, set, set_value, enable, up_down, exp_set, exp_val);
            end
        end
        btn_load = 1'b0;
        sw_value = 4'h3;
        for (int i = 0; i < 12; i++) begin
            tick();
            tests++;
            if (set !== 1'b0 || set_value !== 4'hA) begin
                failed++;
                $display("FAIL load_hold cyc=%0d got set=%b val=%h want 0 a",
                         i, set, set_value);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [6:0] exp;
        sw_value = 4'h5;
        idle(3);
        btn_run  = 1'b1;
        btn_dir  = 1'b1;
        btn_load = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i < 7)       exp = {1'b0, 1'b0, 1'b0, 4'hA};
            else if (i == 7) exp = {1'b1, 1'b1, 1'b1, 4'h5};
            else             exp = {1'b1, 1'b1, 1'b0, 4'h5};
            tests++;
            if ({enable, up_down, set, set_value} !== exp) begin
                failed++;
                $display("FAIL simultaneous tick=%0d got %b want %b",
                         i, {enable, up_down, set, set_value}, exp);
            end
        end
        btn_run  = 1'b0;
        btn_dir  = 1'b0;
        btn_load = 1'b0;
        idle(10);
    endtask

    task automatic test_reset_mid();
        logic exp;
        btn_dir = 1'b1;
        idle(8);
        btn_dir = 1'b0;
        idle(10);
        tests++;
        if (enable !== 1'b1 || up_down !== 1'b0) begin
            failed++;
            $display("FAIL mid_setup got en=%b ud=%b want 1 0", enable, up_down);
        end
        btn_run = 1'b1;
        reset   = 1'b1;
        tick();
        reset = 1'b0;
        tests++;
        if ({enable, up_down, set, set_value} !== 7'b0100000) begin
            failed++;
            $display("FAIL mid_reset got %b want 0100000",
                     {enable, up_down, set, set_value});
        end
        for (int i = 1; i <= 10; i++) begin
            tick();
            exp = (i >= 7);
            tests++;
            if (enable !== exp || up_down !== 1'b1) begin
                failed++;
                $display("FAIL mid_repress tick=%0d got en=%b ud=%b want %b 1",
                         i, enable, up_down, exp);
            end
        end
        btn_run = 1'b0;
        idle(10);
    endtask

    initial begin
        test_reset();
        test_run();
        test_bounce();
        test_load();
        test_simultaneous();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
